// File: rtl/row_seq_pkg.sv
// Shared types and constants for the row sequencer slice.
// ROW_SEQ_PAD_EN enables short rows padded out to WORDS_MAX words.
package row_seq_pkg;

    localparam int unsigned PIX_W        = 12;
    localparam int unsigned PIX_PER_WORD = 16;
    localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;
    localparam int unsigned WORDS_MAX    = 32;

`ifdef ROW_SEQ_PAD_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_STREAM,
        ST_PAD,
        ST_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_STREAM,
        ST_DONE
    } state_e;
`endif

    typedef struct packed {
        logic sol;
        logic eol;
        logic eof;
    } flags_t;

    function automatic logic cfg_legal(input logic [5:0] words, input logic [15:0] rows,
                                       input int unsigned words_max);
`ifdef ROW_SEQ_PAD_EN
        return (words != 6'd0) && (32'(words) <= words_max) && (rows != 16'd0);
`else
        return (32'(words) == words_max) && (rows != 16'd0);
`endif
    endfunction

endpackage

// File: rtl/row_sequencer_if.sv
// Upstream/downstream word streams of the row sequencer; slave is the sequencer side.
interface row_sequencer_if #(
    parameter int unsigned WORD_W = 192
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              sol;
    logic              eol;
    logic              eof;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sol, eol, eof
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sol, eol, eof
    );
endinterface

// File: rtl/row_seq_out_reg.sv
// One-entry valid/ready output register carrying a word plus row/frame flags.
module row_seq_out_reg
    import row_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  flags_t            load_flags,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output flags_t            out_flags,
    output logic              free
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    flags_t            flags_q, flags_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        flags_d = flags_q;
        free    = ~valid_q | out_ready;
        // Data is kept after draining so the last word can be replayed as padding.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            flags_d = load_flags;
        end else if (out_ready) begin
            valid_d = 1'b0;
            flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_flags = flags_q;

endmodule

// File: rtl/row_sequencer.sv
// Frames upstream words into fixed WORDS_MAX-word rows for the buffer stage.
// ROW_SEQ_PAD_EN: short rows are padded with copies of their last word.
module row_sequencer
    import row_seq_pkg::*;
#(
    parameter int unsigned WORDS_MAX = 32,
    parameter int unsigned WORD_W    = 192
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [5:0]      cfg_words,
    input  logic [15:0]     cfg_rows,
    input  logic            start,
    row_sequencer_if.slave  io,
    output logic            buf_rst,
    output logic            busy,
    output logic            cfg_err
);

    localparam logic [4:0] LAST_WORD = 5'(WORDS_MAX - 1);

    state_e            state_q, state_d;
    logic [4:0]        word_cnt_q, word_cnt_d;
    logic [15:0]       row_cnt_q, row_cnt_d;
    logic [15:0]       rows_q, rows_d;
`ifdef ROW_SEQ_PAD_EN
    logic [5:0]        words_q, words_d;
`endif
    logic              buf_rst_q, buf_rst_d;
    logic              cfg_err_q, cfg_err_d;

    logic              load, out_free, at_eol, frame_fin, in_ready;
    logic [WORD_W-1:0] load_data, out_data;
    flags_t            load_flags, out_flags;
    logic              out_valid;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        rows_d     = rows_q;
`ifdef ROW_SEQ_PAD_EN
        words_d    = words_q;
`endif
        cfg_err_d  = 1'b0;
        load       = 1'b0;
        in_ready   = 1'b0;
        load_data  = io.in_data;

        at_eol         = (word_cnt_q == LAST_WORD);
        frame_fin      = (row_cnt_q == rows_q);
        load_flags.sol = (word_cnt_q == '0);
        load_flags.eol = at_eol;
        load_flags.eof = at_eol && (row_cnt_q == rows_q - 16'd1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal(cfg_words, cfg_rows, WORDS_MAX)) begin
                        rows_d  = cfg_rows;
`ifdef ROW_SEQ_PAD_EN
                        words_d = cfg_words;
`endif
                        state_d = ST_FLUSH;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                word_cnt_d = '0;
                row_cnt_d  = '0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                // Once the eof word is loaded, intake stops until it drains.
                in_ready = out_free & ~frame_fin;
                load     = in_ready & io.in_valid;
`ifdef ROW_SEQ_PAD_EN
                if (load && !at_eol && ({1'b0, word_cnt_q} == words_q - 6'd1))
                    state_d = ST_PAD;
`endif
            end
`ifdef ROW_SEQ_PAD_EN
            ST_PAD: begin
                load      = out_free;
                load_data = out_data;
                if (load && at_eol)
                    state_d = ST_STREAM;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (at_eol) begin
                word_cnt_d = '0;
                row_cnt_d  = row_cnt_q + 16'd1;
            end else begin
                word_cnt_d = word_cnt_q + 5'd1;
            end
        end

        if (out_valid && io.out_ready && out_flags.eof)
            state_d = ST_DONE;

        buf_rst_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            rows_q     <= '0;
`ifdef ROW_SEQ_PAD_EN
            words_q    <= '0;
`endif
            buf_rst_q  <= 1'b1;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            rows_q     <= rows_d;
`ifdef ROW_SEQ_PAD_EN
            words_q    <= words_d;
`endif
            buf_rst_q  <= buf_rst_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    row_seq_out_reg #(.WORD_W(WORD_W)) u_out_reg (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .load       (load),
        .load_data  (load_data),
        .load_flags (load_flags),
        .out_ready  (io.out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .free       (out_free)
    );

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.out_data  = out_data;
    assign io.sol       = out_flags.sol;
    assign io.eol       = out_flags.eol;
    assign io.eof       = out_flags.eof;
    assign buf_rst      = buf_rst_q;
    assign cfg_err      = cfg_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_row_sequencer.sv
// Self-checking bench for row_sequencer: config table, reference row model, directed corners.
module tb_row_sequencer;

    localparam int unsigned W = 192;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cfg_words;
    logic [15:0] cfg_rows;
    logic        start;
    logic        buf_rst, busy, cfg_err;

    row_sequencer_if #(.WORD_W(W)) bus ();

    row_sequencer #(.WORDS_MAX(32), .WORD_W(W)) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .cfg_words (cfg_words),
        .cfg_rows  (cfg_rows),
        .start     (start),
        .io        (bus.slave),
        .buf_rst   (buf_rst),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         sol;
        logic         eol;
        logic         eof;
    } word_t;

    typedef struct {
        int words;
        int rows;
        bit err;
    } cfg_vec_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Expected row stream: each row is its active source words followed by
    // copies of the row's last active word up to 32 words.
    task automatic run_frame(input int words, input int rows, input int vprob, input int rprob,
                             input int stall_at, input int abort_at, output bit aborted);
        logic [W-1:0] src[$];
        word_t        exp[$];
        word_t        e, pw;
        int           nacc, nout, stall, total;
        bit           pv, pr, stalling;
        aborted = 1'b0;
        for (int r = 0; r < rows; r++)
            for (int i = 0; i < words; i++) src.push_back(rand_word());
        for (int r = 0; r < rows; r++)
            for (int i = 0; i < 32; i++) begin
                e.data = src[r*words + ((i < words) ? i : words - 1)];
                e.sol  = (i == 0);
                e.eol  = (i == 31);
                e.eof  = (i == 31) && (r == rows - 1);
                exp.push_back(e);
            end
        total = exp.size();

        @(posedge clk); #1;
        cfg_words = 6'(words); cfg_rows = 16'(rows); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("flush_buf_rst", buf_rst, 1);
        chk("flush_busy", busy, 1);
        chk("legal_cfg_err", cfg_err, 0);

        nacc = 0; nout = 0; stall = 0; pv = 0; pr = 0; pw = e;
        for (int cyc = 0; cyc < 20000 && nout < total; cyc++) begin
            @(posedge clk); #1;
            bus.in_valid  = (nacc < src.size()) && ($urandom_range(99) < vprob);
            bus.in_data   = bus.in_valid ? src[nacc] : rand_word();
            stalling      = (stall_at >= 0) && (nout >= stall_at) && (stall < 5) && bus.out_valid;
            bus.out_ready = !stalling && ($urandom_range(99) < rprob);
            if (stalling) stall++;
            cfg_words = 6'($urandom);
            cfg_rows  = 16'($urandom);
            start     = ($urandom_range(15) == 0);
            #1;
            if (cyc == 0) chk("flush_end_buf_rst", buf_rst, 0);
            if (abort_at >= 0 && bus.out_valid && nout == abort_at) begin
                rst = 1'b1; start = 1'b0; aborted = 1'b1;
                return;
            end
            if (pv && !pr) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, pw.data);
                chk("hold_flags", {bus.sol, bus.eol, bus.eof}, {pw.sol, pw.eol, pw.eof});
            end
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
            if (nacc >= src.size()) chk("in_ready_after_last", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) nacc++;
            if (bus.out_valid && bus.out_ready) begin
                chk("word_data", bus.out_data, exp[nout].data);
                chk("word_flags", {bus.sol, bus.eol, bus.eof},
                    {exp[nout].sol, exp[nout].eol, exp[nout].eof});
                nout++;
            end
            pv = bus.out_valid; pr = bus.out_ready;
            pw.data = bus.out_data; pw.sol = bus.sol; pw.eol = bus.eol; pw.eof = bus.eof;
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        if (nout < total) chk("frame_timeout", nout, total);
        chk("accepted_count", nacc, src.size());
        @(posedge clk); #2;
        chk("done_busy", busy, 1);
        chk("done_in_ready", bus.in_ready, 0);
        chk("done_out_valid", bus.out_valid, 0);
        @(posedge clk); #2;
        chk("idle_busy", busy, 0);
    endtask

    cfg_vec_t tbl[$];
    bit       ab;
    int       rw;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_words = '0; cfg_rows = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_buf_rst", buf_rst, 1);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_flags", {bus.sol, bus.eol, bus.eof}, 3'b000);
        chk("rst_out_data", bus.out_data, '0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_buf_rst_end", buf_rst, 0);

        tbl.push_back('{0, 3, 1});
        tbl.push_back('{33, 2, 1});
        tbl.push_back('{63, 1, 1});
        tbl.push_back('{32, 0, 1});
        tbl.push_back('{32, 2, 0});
        tbl.push_back('{32, 1, 0});
`ifdef ROW_SEQ_PAD_EN
        tbl.push_back('{30, 2, 0});
        tbl.push_back('{1, 1, 0});
        tbl.push_back('{31, 2, 0});
`else
        tbl.push_back('{30, 2, 1});
        tbl.push_back('{1, 1, 1});
`endif
        foreach (tbl[k]) begin
            if (tbl[k].err) begin
                @(posedge clk); #1;
                cfg_words = 6'(tbl[k].words); cfg_rows = 16'(tbl[k].rows); start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                #1;
                chk("rej_cfg_err", cfg_err, 1);
                chk("rej_busy", busy, 0);
                chk("rej_buf_rst", buf_rst, 0);
                @(posedge clk); #2;
                chk("rej_cfg_err_pulse", cfg_err, 0);
                chk("rej_busy_after", busy, 0);
            end else begin
                run_frame(tbl[k].words, tbl[k].rows, 100, 100, -1, -1, ab);
            end
        end

        for (int n = 0; n < 6; n++) begin
`ifdef ROW_SEQ_PAD_EN
            rw = int'($urandom_range(32, 1));
`else
            rw = 32;
`endif
            run_frame(rw, int'($urandom_range(3, 1)), int'($urandom_range(100, 50)),
                      int'($urandom_range(100, 40)), -1, -1, ab);
        end

`ifdef ROW_SEQ_PAD_EN
        run_frame(30, 2, 100, 100, 10, -1, ab);
`else
        run_frame(32, 2, 100, 100, 10, -1, ab);
`endif

        run_frame(32, 3, 100, 100, -1, 42, ab);
        chk("abort_reached", ab, 1);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_buf_rst", buf_rst, 1);
        chk("abort_out_data", bus.out_data, '0);
        run_frame(32, 1, 80, 80, -1, -1, ab);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/row_sequencer.md
ROW_SEQUENCER -- requirements
Module: row_sequencer

Interface
REQ-001 Parameter WORDS_MAX, default 32, words per row the buffer stage holds (its 5-bit address space).
REQ-002 Parameter WORD_W, default 192, width of one 16-pixel x 12-bit word.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 cfg_words  in  6  active words per row, legal 1..32.
REQ-006 cfg_rows  in  16  rows per frame, legal 1..65535.
REQ-007 start  in  1  one-cycle pulse; latches cfg_* and begins a frame.
REQ-008 in_valid / in_ready  in / out  1 / 1  upstream word handshake.
REQ-009 in_data  in  WORD_W  upstream pixel word.
REQ-010 out_valid  out  1  drives buffer-stage input_valid.
REQ-011 out_data  out  WORD_W  drives buffer-stage pixel inputs.
REQ-012 out_ready  in  1  downstream encoder accepts word.
REQ-013 buf_rst  out  1  one-cycle reset pulse to buffer stage.
REQ-014 sol, eol, eof  out  1 each  flags aligned with out_valid word: first/last word of row, last word of frame.
REQ-015 busy  out  1  high outside IDLE.
REQ-016 cfg_err  out  1  one-cycle pulse on rejected start.

Function
REQ-017 FSM states IDLE, FLUSH, STREAM, PAD, DONE; encoding in shared package.
REQ-018 IDLE + start with legal cfg -> latch cfg, FLUSH; illegal (cfg_words==0, >32, or cfg_rows==0) -> pulse cfg_err, stay IDLE.
REQ-019 FLUSH lasts exactly 1 cycle with buf_rst=1, then STREAM; word_cnt=0, row_cnt=0.
REQ-020 Output is a one-entry register stage: in_ready = (state==STREAM) & (~out_valid | out_ready); transfer on in_valid&in_ready; latency 1 cycle.
REQ-021 out_valid/out_data/flags held stable while out_valid & ~out_ready.
REQ-022 word_cnt (5 bit) increments per emitted word, wraps 31->0 at end of each row; row_cnt increments at row end.
REQ-023 sol=1 when word_cnt==0; eol=1 when word_cnt==31; eof=eol & row_cnt==cfg_rows-1.
REQ-024 After accepting active word cfg_words-1 with cfg_words<32 -> PAD; PAD emits 32-cfg_words copies of last accepted word, in_ready=0.
REQ-025 Row end with row_cnt==cfg_rows-1 -> DONE once eof word accepted by out_ready; DONE -> IDLE after 1 cycle.
REQ-026 start while busy ignored; cfg_* changes while busy ignored.
REQ-027 row_cnt 16-bit, never wraps within a legal frame.

Reset
REQ-028 sys_rst: state=IDLE, out_valid=0, out_data=0, sol/eol/eof=0, buf_rst=1 (one cycle), cfg_err=0, busy=0, counters=0, in_ready=0.
REQ-029 sys_rst mid-frame aborts immediately; no partial row completed; takes priority over all other events.

Configuration
REQ-030 ROW_SEQ_PAD_EN defined: PAD state and REQ-024 present.
REQ-031 ROW_SEQ_PAD_EN undefined: no PAD state; cfg_words!=32 rejected by cfg_err; rows always 32 source words.

Structure
REQ-032 Package row_seq_pkg: state enum, WORDS_MAX, WORD_W, PIX_W=12, PIX_PER_WORD=16.
REQ-033 Sub-module row_seq_out_reg (one-entry valid/ready register with data+flags) instantiated once.

Verification
REQ-034 cfg_words=32, cfg_rows=2, start, continuous valid/ready -> buf_rst 1 cycle, 64 words, eol at words 31/63, eof on word 63, busy drops.
REQ-035 cfg_words=30 (PAD_EN) -> per row 30 accepted words + 2 copies of word 29, in_ready=0 during pad, eol on pad copy 2.
REQ-036 out_ready low 5 cycles mid-row -> out_data/flags stable, in_ready=0, no word lost or duplicated.
REQ-037 start with cfg_words=0 or cfg_rows=0 -> cfg_err pulse, busy stays 0, no buf_rst.
REQ-038 sys_rst at row 1 word 10 -> next cycle IDLE, out_valid=0; new start yields sol on first word.
REQ-039 start pulse while busy -> ignored, frame completes with original cfg.
